return_stack: RTL and testbench



---
 rtl/cpu19_pkg.sv | 26 ++
 rtl/lifo_mem.sv | 31 +++
 rtl/return_stack.sv | 160 ++++++++++++++++
 tb/tb_return_stack.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu19_pkg.sv
// Shared definitions for the 19-bit CPU: word width, control-unit opcodes
// and the request bundle the control unit drives into the return stack.
package cpu19_pkg;

    localparam int WORD_W = 19;
    localparam int OP_W   = 5;

    localparam logic [OP_W-1:0] OP_PUSH = 5'h08;
    localparam logic [OP_W-1:0] OP_POP  = 5'h09;
    localparam logic [OP_W-1:0] OP_CALL = 5'h0A;
    localparam logic [OP_W-1:0] OP_RET  = 5'h0B;
    localparam logic [OP_W-1:0] OP_JMP  = 5'h0C;

    typedef struct packed {
        logic push;
        logic pop;
        logic ret;
    } stack_req_t;

    // True for the opcodes that touch the return stack.
    function automatic logic is_stack_op(input logic [OP_W-1:0] opcode);
        return (opcode == OP_PUSH) || (opcode == OP_POP) ||
               (opcode == OP_CALL) || (opcode == OP_RET);
    endfunction

endpackage

// File: rtl/lifo_mem.sv
// Stack storage: DEPTH x WORD_W register array, one write port and two
// combinational read ports (current top and the entry beneath it).
module lifo_mem #(
    parameter  int WORD_W = cpu19_pkg::WORD_W,
    parameter  int DEPTH  = 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr_top,
    input  logic [AW-1:0]     raddr_below,
    output logic [WORD_W-1:0] rdata_top,
    output logic [WORD_W-1:0] rdata_below
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    // NOTE: the array is deliberately left out of reset; validity is tracked
    // by the occupancy counter, so resetting every entry would only add logic.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_top   = mem_q[raddr_top];
    assign rdata_below = mem_q[raddr_below];

endmodule

// File: rtl/return_stack.sv
// Hardware LIFO for PUSH/POP data and CALL/RET return addresses, with a
// registered read port and sticky overflow/underflow flags.
module return_stack #(
    parameter  int WORD_W = cpu19_pkg::WORD_W,
    parameter  int DEPTH  = 8,
    parameter  int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hazard,
    input  logic              push,
    input  logic              pop,
    input  logic              ret,
    input  logic [WORD_W-1:0] push_data,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              ret_valid,
    output logic [WORD_W-1:0] top,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow
);

    import cpu19_pkg::*;

    localparam int AW = $clog2(DEPTH);

    stack_req_t        req;
    logic              wr;
    logic              rm;

    logic [CNT_W-1:0]  count_q, count_d;
    logic [WORD_W-1:0] top_q, top_d;
    logic [WORD_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              ret_valid_q, ret_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              is_full;
    logic              is_empty;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [AW-1:0]     raddr_top;
    logic [AW-1:0]     raddr_below;
    logic [WORD_W-1:0] rdata_top;
    logic [WORD_W-1:0] rdata_below;

    assign is_full     = (count_q == CNT_W'(DEPTH));
    assign is_empty    = (count_q == '0);
    // Indices wrap when the stack is nearly empty; those reads are never used.
    assign raddr_top   = count_q[AW-1:0] - AW'(1);
    assign raddr_below = count_q[AW-1:0] - AW'(2);

    lifo_mem #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk         (clk),
        .we          (mem_we),
        .waddr       (mem_waddr),
        .wdata       (push_data),
        .raddr_top   (raddr_top),
        .raddr_below (raddr_below),
        .rdata_top   (rdata_top),
        .rdata_below (rdata_below)
    );

    // NOTE: every signal driven here gets its default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        req         = '{push: push, pop: pop, ret: ret};
        wr          = req.push & ~hazard;
        rm          = (req.pop | req.ret) & ~hazard;

        count_d     = count_q;
        top_d       = top_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        ret_valid_d = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        mem_we      = 1'b0;
        mem_waddr   = count_q[AW-1:0];

        case ({wr, rm})
            2'b10: begin
                if (is_full) begin
                    overflow_d = 1'b1;
                end else begin
                    mem_we  = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    top_d   = push_data;
                end
            end
            2'b01: begin
                if (is_empty) begin
                    underflow_d = 1'b1;
                end else begin
                    rd_data_d   = rdata_top;
                    rd_valid_d  = 1'b1;
                    ret_valid_d = req.ret;
                    count_d     = count_q - CNT_W'(1);
                    top_d       = (count_q == CNT_W'(1)) ? '0 : rdata_below;
                end
            end
            2'b11: begin
                mem_we = 1'b1;
                top_d  = push_data;
                if (is_empty) begin
                    // Push still lands in slot 0; only the removal is refused.
                    count_d     = CNT_W'(1);
                    underflow_d = 1'b1;
                end else begin
                    // Swap: the top slot is overwritten, so full is no obstacle.
                    mem_waddr   = raddr_top;
                    rd_data_d   = rdata_top;
                    rd_valid_d  = 1'b1;
                    ret_valid_d = req.ret;
                end
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            top_q       <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            ret_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            top_q       <= top_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            ret_valid_q <= ret_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign ret_valid = ret_valid_q;
    assign top       = top_q;
    assign count     = count_q;
    assign full      = is_full;
    assign empty     = is_empty;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_return_stack.sv
// Self-checking bench for return_stack: queue-based reference model, directed
// scenarios followed by random traffic, rd_data checked by a scoreboard monitor.
module tb_return_stack;

    localparam int WORD_W = 19;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    typedef struct {
        logic [WORD_W-1:0] data;
        logic              ret;
    } rd_exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              hazard = 1'b0;
    logic              push = 1'b0;
    logic              pop = 1'b0;
    logic              ret = 1'b0;
    logic [WORD_W-1:0] push_data = '0;
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;
    logic              ret_valid;
    logic [WORD_W-1:0] top;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              underflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: stack as a queue (last element is the top).
    logic [WORD_W-1:0] stk[$];
    logic              m_ovf = 1'b0;
    logic              m_unf = 1'b0;
    logic              m_rv  = 1'b0;
    logic              m_retv = 1'b0;
    rd_exp_t           exp_rd[$];

    return_stack #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hazard    (hazard),
        .push      (push),
        .pop       (pop),
        .ret       (ret),
        .push_data (push_data),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .ret_valid (ret_valid),
        .top       (top),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [WORD_W-1:0] model_top();
        return (stk.size() == 0) ? '0 : stk[stk.size()-1];
    endfunction

    // Compare everything observable against the model (called away from posedge).
    task automatic check_state(input string tag);
        check({tag, ".count"},     32'(count),     32'(stk.size()));
        check({tag, ".top"},       32'(top),       32'(model_top()));
        check({tag, ".full"},      32'(full),      32'(stk.size() == DEPTH));
        check({tag, ".empty"},     32'(empty),     32'(stk.size() == 0));
        check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
        check({tag, ".rd_valid"},  32'(rd_valid),  32'(m_rv));
        check({tag, ".ret_valid"}, 32'(ret_valid), 32'(m_retv));
    endtask

    // One clock of stimulus: drive after negedge, update model, check at next negedge.
    task automatic step(input string tag, input logic hz, input logic pu, input logic po,
                        input logic rt, input logic [WORD_W-1:0] d);
        logic    wr;
        logic    rm;
        rd_exp_t e;
        hazard    = hz;
        push      = pu;
        pop       = po;
        ret       = rt;
        push_data = d;
        wr     = pu & ~hz;
        rm     = (po | rt) & ~hz;
        m_rv   = 1'b0;
        m_retv = 1'b0;
        if (wr && rm) begin
            if (stk.size() == 0) begin
                stk.push_back(d);
                m_unf = 1'b1;
            end else begin
                e.data = stk[stk.size()-1];
                e.ret  = rt;
                exp_rd.push_back(e);
                stk[stk.size()-1] = d;
                m_rv   = 1'b1;
                m_retv = rt;
            end
        end else if (wr) begin
            if (stk.size() == DEPTH) m_ovf = 1'b1;
            else stk.push_back(d);
        end else if (rm) begin
            if (stk.size() == 0) begin
                m_unf = 1'b1;
            end else begin
                e.data = stk.pop_back();
                e.ret  = rt;
                exp_rd.push_back(e);
                m_rv   = 1'b1;
                m_retv = rt;
            end
        end
        @(posedge clk);
        @(negedge clk);
        hazard = 1'b0;
        push   = 1'b0;
        pop    = 1'b0;
        ret    = 1'b0;
        check_state(tag);
    endtask

    // Assert reset between edges; outputs must take reset values at once.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        stk.delete();
        exp_rd.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_rv   = 1'b0;
        m_retv = 1'b0;
        #1;
        check_state(tag);
        check({tag, ".rd_data"}, 32'(rd_data), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: every rd_valid pulse must match the oldest expectation.
    initial begin
        rd_exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rd_valid) begin
                check("rd_expected", 32'(exp_rd.size() != 0), 32'(1));
                if (exp_rd.size() != 0) begin
                    e = exp_rd.pop_front();
                    check("rd_data",        32'(rd_data),   32'(e.data));
                    check("rd_ret_valid",   32'(ret_valid), 32'(e.ret));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        do_reset("reset");

        // LIFO order with back-to-back pops.
        step("push1", 0, 1, 0, 0, 19'h00001);
        step("push2", 0, 1, 0, 0, 19'h7FFFF);
        step("push3", 0, 1, 0, 0, 19'h12345);
        for (int i = 0; i < 3; i++) step("pop", 0, 0, 1, 0, '0);

        // Fill, overflow, then ret.
        for (int i = 1; i <= DEPTH; i++) step("fill", 0, 1, 0, 0, WORD_W'(i));
        step("ovf_push", 0, 1, 0, 0, 19'h0AAAA);
        step("ret_full", 0, 0, 0, 1, '0);

        // Underflow is sticky across a later accepted push.
        do_reset("reset2");
        step("pop_empty", 0, 0, 1, 0, '0);
        step("push_after_unf", 0, 1, 0, 0, 19'h00042);

        // Hazard freezes requests; release executes them (a swap here).
        step("pre_hz", 0, 1, 0, 0, 19'h00003);
        for (int i = 0; i < 3; i++) step("hazard", 1, 1, 1, 0, 19'h00055);
        step("hz_release", 0, 1, 1, 0, 19'h00055);

        // Swap with ret, then swap at full without overflow.
        do_reset("reset3");
        step("p5", 0, 1, 0, 0, 19'h00005);
        step("p6", 0, 1, 0, 0, 19'h00006);
        step("swap_ret", 0, 1, 0, 1, 19'h00009);
        for (int i = 0; i < DEPTH - 2; i++) step("fill2", 0, 1, 0, 0, WORD_W'(19'h100 + i));
        step("swap_full", 0, 1, 0, 1, 19'h00077);
        step("pop_swapped", 0, 0, 1, 0, '0);

        // Simultaneous push+pop on empty: push taken, underflow set.
        do_reset("reset4");
        step("swap_empty", 0, 1, 1, 0, 19'h00033);

        // Mid-sequence reset drops a pending pulse; next pop underflows.
        do_reset("reset5");
        for (int i = 0; i < 4; i++) step("fill4", 0, 1, 0, 0, WORD_W'(19'h200 + i));
        step("pop_before_rst", 0, 0, 1, 0, '0);
        do_reset("mid_reset");
        step("pop_after_rst", 0, 0, 1, 0, '0);

        // Random traffic against the model.
        do_reset("reset6");
        for (int i = 0; i < 600; i++) begin
            logic              hz;
            logic              pu;
            logic              po;
            logic              rt;
            int unsigned       op;
            hz = ($urandom_range(0, 7) == 0);
            op = $urandom_range(0, 9);
            pu = (op <= 4) || (op == 8);
            po = (op == 5) || (op == 6) || (op == 8);
            rt = (op == 7) || (op == 9);
            if (op == 9) pu = 1'b1;
            step("rand", hz, pu, po, rt, WORD_W'($urandom));
            if (i == 300) do_reset("rand_reset");
        end

        @(negedge clk);
        check("rd_queue_drained", 32'(exp_rd.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
